// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM encoding, timeout
// defaults and a small state helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arbStateT;

  localparam int TMO_DEFAULT = 15;
  localparam int CTR_W       = 4;

  function automatic logic isBusy(arbStateT s);
    return (s == I_BUSY) || (s == D_BUSY);
  endfunction

endpackage

// File: rtl/arb_timeout_ctr.sv
// Timeout counter for an outstanding memory transaction. Counts BUSY cycles
// without an acknowledge; termCount flags the cycle whose increment would
// make the count reach TMO, so the arbiter gives up on that same edge.
module arb_timeout_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int TMO = TMO_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic termCount
);

  localparam logic [CTR_W-1:0] LAST = CTR_W'(TMO - 1);

  logic [CTR_W-1:0] count;

  // Cycle counter: cleared on grant, advanced on every un-acknowledged BUSY cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CTR_W'(1);
    end
  end

  assign termCount = enable && !clear && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the
// data stage. One transaction outstanding at most; data wins ties.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no transaction; grant evaluated unless a ready is pulsing
//   I_BUSY | fetch in flight, mRd held until mAck or timeout
//   D_BUSY | data read/write in flight, mRd/mWr held until mAck or timeout
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int TMO = TMO_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifReq,
  input  logic [AW-1:0] ifAddr,
  output logic [DW-1:0] ifRdata,
  output logic          ifReady,
  input  logic          memRd,
  input  logic          memWr,
  input  logic [AW-1:0] dAddr,
  input  logic [DW-1:0] dWdata,
  output logic [DW-1:0] dRdata,
  output logic          dReady,
  output logic [AW-1:0] mAddr,
  output logic [DW-1:0] mWdata,
  output logic          mRd,
  output logic          mWr,
  input  logic [DW-1:0] mRdata,
  input  logic          mAck,
  output logic          stallF,
  output logic          stallM,
  output logic          busErr
);

  arbStateT      state, stateNext;
  logic [AW-1:0] mAddrNext;
  logic [DW-1:0] mWdataNext, ifRdataNext, dRdataNext;
  logic          mRdNext, mWrNext, ifReadyNext, dReadyNext, busErrNext;
  logic          ctrClear, ctrEnable, tmoHit;

  assign ctrEnable = isBusy(state) && !mAck;

  arb_timeout_ctr #(.TMO(TMO)) uTimeout (
    .clk       (clk),
    .rst       (rst),
    .clear     (ctrClear),
    .enable    (ctrEnable),
    .termCount (tmoHit)
  );

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      mAddr   <= '0;
      mWdata  <= '0;
      mRd     <= 1'b0;
      mWr     <= 1'b0;
      ifRdata <= '0;
      dRdata  <= '0;
      ifReady <= 1'b0;
      dReady  <= 1'b0;
      busErr  <= 1'b0;
    end else begin
      state   <= stateNext;
      mAddr   <= mAddrNext;
      mWdata  <= mWdataNext;
      mRd     <= mRdNext;
      mWr     <= mWrNext;
      ifRdata <= ifRdataNext;
      dRdata  <= dRdataNext;
      ifReady <= ifReadyNext;
      dReady  <= dReadyNext;
      busErr  <= busErrNext;
    end
  end

  // Grant, completion and timeout decisions.
  always_comb begin
    stateNext   = state;
    mAddrNext   = mAddr;
    mWdataNext  = mWdata;
    mRdNext     = mRd;
    mWrNext     = mWr;
    ifRdataNext = ifRdata;
    dRdataNext  = dRdata;
    ifReadyNext = 1'b0;
    dReadyNext  = 1'b0;
    busErrNext  = busErr;
    ctrClear    = 1'b0;
    case (state)
      IDLE: begin
        // The requester that just got its ready pulse still shows its
        // request this cycle, so grants wait one cycle after any ready.
        if (!ifReady && !dReady) begin
          if (memRd || memWr) begin
            stateNext  = D_BUSY;
            mAddrNext  = dAddr;
            mWdataNext = dWdata;
            mRdNext    = memRd;
            mWrNext    = memWr;
            ctrClear   = 1'b1;
          end else if (ifReq) begin
            stateNext = I_BUSY;
            mAddrNext = ifAddr;
            mRdNext   = 1'b1;
            mWrNext   = 1'b0;
            ctrClear  = 1'b1;
          end
        end
      end
      I_BUSY: begin
        if (mAck || tmoHit) begin
          ifRdataNext = mAck ? mRdata : '0;
          ifReadyNext = 1'b1;
          busErrNext  = busErr | !mAck;
          mRdNext     = 1'b0;
          mWrNext     = 1'b0;
          stateNext   = IDLE;
        end
      end
      D_BUSY: begin
        if (mAck || tmoHit) begin
          // Writes return nothing, so a write never disturbs dRdata.
          if (!mWr) begin
            dRdataNext = mAck ? mRdata : '0;
          end
          dReadyNext = 1'b1;
          busErrNext = busErr | !mAck;
          mRdNext    = 1'b0;
          mWrNext    = 1'b0;
          stateNext  = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
        mRdNext   = 1'b0;
        mWrNext   = 1'b0;
      end
    endcase
  end

  assign stallF = ifReq & ~ifReady;
  assign stallM = (memRd | memWr) & ~dReady;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// transactions checked against a transaction-level expectation model.
module tb_mem_port_arbiter;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic [31:0] ifRdata;
  logic        ifReady;
  logic        memRd, memWr;
  logic [31:0] dAddr, dWdata, dRdata;
  logic        dReady;
  logic [31:0] mAddr, mWdata, mRdata;
  logic        mRd, mWr, mAck;
  logic        stallF, stallM, busErr;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [31:0] expIfRdata, expDRdata, expMAddr;
  logic        expBusErr;

  mem_port_arbiter #(.DW(32), .AW(32), .TMO(TMO)) dut (
    .clk     (clk),
    .rst     (rst),
    .ifReq   (ifReq),
    .ifAddr  (ifAddr),
    .ifRdata (ifRdata),
    .ifReady (ifReady),
    .memRd   (memRd),
    .memWr   (memWr),
    .dAddr   (dAddr),
    .dWdata  (dWdata),
    .dRdata  (dRdata),
    .dReady  (dReady),
    .mAddr   (mAddr),
    .mWdata  (mWdata),
    .mRd     (mRd),
    .mWr     (mWr),
    .mRdata  (mRdata),
    .mAck    (mAck),
    .stallF  (stallF),
    .stallM  (stallM),
    .busErr  (busErr)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkStalls(input logic ifRdyExp, input logic dRdyExp);
    #1;
    chk("stallF", stallF, ifReq & ~ifRdyExp);
    chk("stallM", stallM, (memRd | memWr) & ~dRdyExp);
  endtask

  // Called in the first cycle after the grant edge; returns in the ready cycle
  // after checking it. kind: 0 fetch, 1 data read, 2 data write.
  task automatic runTxn(input int kind, input logic [31:0] addr, input int delay,
                        input logic [31:0] wdata, input logic [31:0] rdVal,
                        input logic dropEarly);
    logic timedOut;
    timedOut = (delay >= TMO);
    expMAddr = addr;
    for (int k = 1; k <= TMO; k++) begin
      chk("busy mRd", mRd, kind != 2);
      chk("busy mWr", mWr, kind == 2);
      chk("busy mAddr", mAddr, expMAddr);
      if (kind == 2) chk("busy mWdata", mWdata, wdata);
      chk("busy no ready", {ifReady, dReady}, 2'b00);
      if (dropEarly && k == 1) begin
        if (kind == 0) ifReq = 1'b0;
        else begin
          memRd = 1'b0;
          memWr = 1'b0;
        end
      end
      checkStalls(1'b0, 1'b0);
      if (!timedOut && k == delay + 1) begin
        mAck   = 1'b1;
        mRdata = rdVal;
        tick();
        mAck   = 1'b0;
        mRdata = $urandom;
        break;
      end
      tick();
      if (timedOut && k == TMO) break;
    end
    if (timedOut) expBusErr = 1'b1;
    if (kind == 0) expIfRdata = timedOut ? 32'h0 : rdVal;
    if (kind == 1) expDRdata = timedOut ? 32'h0 : rdVal;
    chk("ifReady pulse", ifReady, kind == 0);
    chk("dReady pulse", dReady, kind != 0);
    chk("ifRdata", ifRdata, expIfRdata);
    chk("dRdata", dRdata, expDRdata);
    chk("busErr", busErr, expBusErr);
    chk("mem released", {mRd, mWr}, 2'b00);
    chk("mAddr hold", mAddr, expMAddr);
    checkStalls(kind == 0, kind != 0);
    if (kind == 0) ifReq = 1'b0;
    else begin
      memRd = 1'b0;
      memWr = 1'b0;
    end
  endtask

  // dKind: 0 none, 1 read, 2 write. Starts in an IDLE cycle with no ready pulsing.
  task automatic scenario(input logic hasF, input int dKind,
                          input logic [31:0] fA, input logic [31:0] dA, input logic [31:0] dW,
                          input int fDly, input int dDly,
                          input logic [31:0] fVal, input logic [31:0] dVal,
                          input logic dropF, input logic dropD);
    ifReq  = hasF;
    ifAddr = fA;
    memRd  = (dKind == 1);
    memWr  = (dKind == 2);
    dAddr  = dA;
    dWdata = dW;
    checkStalls(1'b0, 1'b0);
    tick();
    if (dKind != 0) begin
      runTxn(dKind, dA, dDly, dW, dVal, dropD);
      tick();
      chk("dReady single", dReady, 1'b0);
      if (hasF) begin
        chk("fetch waits", mRd, 1'b0);
        checkStalls(1'b0, 1'b0);
        tick();
      end
    end
    if (hasF) begin
      runTxn(0, fA, fDly, 32'h0, fVal, dropF);
      tick();
      chk("ifReady single", ifReady, 1'b0);
    end
  endtask

  // Idle cycles with stray acknowledges, which must change nothing.
  task automatic idleGap(input int n);
    for (int i = 0; i < n; i++) begin
      mAck   = ($urandom_range(0, 1) == 1);
      mRdata = $urandom;
      tick();
      chk("idle ready", {ifReady, dReady}, 2'b00);
      chk("idle mem", {mRd, mWr}, 2'b00);
      chk("idle ifRdata", ifRdata, expIfRdata);
      chk("idle dRdata", dRdata, expDRdata);
      chk("idle mAddr", mAddr, expMAddr);
      chk("idle busErr", busErr, expBusErr);
    end
    mAck = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, " ifRdata"}, ifRdata, 32'h0);
    chk({tag, " dRdata"}, dRdata, 32'h0);
    chk({tag, " mAddr"}, mAddr, 32'h0);
    chk({tag, " mWdata"}, mWdata, 32'h0);
    chk({tag, " mRd/mWr"}, {mRd, mWr}, 2'b00);
    chk({tag, " ready"}, {ifReady, dReady}, 2'b00);
    chk({tag, " busErr"}, busErr, 1'b0);
  endtask

  initial begin
    int pick, fDly, dDly, dKind;
    logic hasF;
    rst = 1'b0; ifReq = 1'b0; ifAddr = '0; memRd = 1'b0; memWr = 1'b0;
    dAddr = '0; dWdata = '0; mRdata = '0; mAck = 1'b0;
    expIfRdata = '0; expDRdata = '0; expMAddr = '0; expBusErr = 1'b0;
    repeat (3) tick();
    checkAllZero("reset");
    rst = 1'b1;
    idleGap(2);

    // Single fetch, acknowledged one cycle after mRd rises.
    scenario(1'b1, 0, 32'h40, 32'h0, 32'h0, 1, 0, 32'h8C010004, 32'h0, 1'b0, 1'b0);
    chk("fetch result", ifRdata, 32'h8C010004);
    idleGap(2);

    // Simultaneous fetch and load: load first, fetch one IDLE cycle after dReady.
    scenario(1'b1, 1, 32'h200, 32'h100, 32'h0, 0, 0, 32'h11112222, 32'h33334444, 1'b0, 1'b0);
    idleGap(2);

    // Store: dRdata keeps the load value.
    scenario(1'b0, 2, 32'h0, 32'h20, 32'hDEADBEEF, 0, 3, 32'h0, 32'h55555555, 1'b0, 1'b0);
    chk("store keeps dRdata", dRdata, 32'h33334444);
    idleGap(2);

    // Load dropped mid-transaction still completes.
    scenario(1'b0, 1, 32'h0, 32'h44, 32'h0, 0, 2, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b1);
    idleGap(1);

    for (int n = 0; n < 80; n++) begin
      pick  = $urandom_range(0, 4);
      hasF  = (pick == 0) || (pick >= 3);
      dKind = (pick == 1 || pick == 3) ? 1 : (pick == 2 || pick == 4) ? 2 : 0;
      fDly  = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO, TMO + 2) : $urandom_range(0, 3);
      if (dKind == 2)
        dDly = ($urandom_range(0, 9) == 0) ? TMO - 1 : $urandom_range(0, 3);
      else
        dDly = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO, TMO + 2) : $urandom_range(0, 3);
      scenario(hasF, dKind, $urandom, $urandom, $urandom, fDly, dDly, $urandom, $urandom,
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      idleGap($urandom_range(1, 3));
    end

    // Fetch never acknowledged: timeout, zero data, sticky busErr.
    scenario(1'b1, 0, 32'h80, 32'h0, 32'h0, TMO + 5, 0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
    chk("timeout data", ifRdata, 32'h0);
    chk("timeout busErr", busErr, 1'b1);
    idleGap(100);
    chk("busErr sticky", busErr, 1'b1);

    // Reset during a load abandons it; a later ack is ignored.
    memRd = 1'b1; dAddr = 32'h300;
    tick();
    chk("pre-reset mRd", mRd, 1'b1);
    tick();
    rst = 1'b0; memRd = 1'b0;
    tick();
    rst = 1'b1;
    expIfRdata = '0; expDRdata = '0; expMAddr = '0; expBusErr = 1'b0;
    checkAllZero("mid reset");
    mAck = 1'b1; mRdata = 32'h12345678;
    tick();
    mAck = 1'b0;
    checkAllZero("post reset ack");
    idleGap(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter DW, default 32: data width.
REQ-002 Parameter AW, default 32: address width.
REQ-003 Parameter TMO, default 15: timeout in cycles, range 1..15.
REQ-004 clk  in  1: single clock; all state changes on its rising edge.
REQ-005 rst  in  1: reset, synchronous and active-low.
REQ-006 ifReq  in  1: fetch request, held until ifReady.
REQ-007 ifAddr  in  AW: fetch address.
REQ-008 ifRdata  out  DW: registered fetched instruction.
REQ-009 ifReady  out  1: one-cycle pulse, fetch complete.
REQ-010 memRd, memWr  in  1 each: data read or write request, held until dReady; never both set.
REQ-011 dAddr, dWdata  in  AW, DW: data address and write data.
REQ-012 dRdata  out  DW: registered load data.
REQ-013 dReady  out  1: one-cycle pulse, data access complete.
REQ-014 mAddr, mWdata, mRd, mWr  out  AW, DW, 1, 1: shared single-port memory request.
REQ-015 mRdata, mAck  in  DW, 1: memory read data; completion strobe.
REQ-016 stallF  out  1: fetch stage must hold (gates PcWrite/IRWrite).
REQ-017 stallM  out  1: memory stage and everything older must hold.
REQ-018 busErr  out  1: sticky timeout flag.

Function
REQ-019 States IDLE, I_BUSY, D_BUSY; one transaction outstanding at most.
REQ-020 IDLE: memRd|memWr -> latch dAddr/dWdata/kind, go D_BUSY; else ifReq -> latch ifAddr, go I_BUSY; else stay.
REQ-021 Data wins over fetch when both request in the same IDLE cycle.
REQ-022 mRd/mWr assert from the cycle after grant until the mAck cycle inclusive; mAddr/mWdata hold latched values throughout.
REQ-023 In IDLE, mRd=mWr=0, and mAddr and mWdata hold their last values.
REQ-024 BUSY with mAck=1: read captures mRdata into ifRdata or dRdata; the matching ready pulses in the next cycle; state returns to IDLE.
REQ-025 Write completion leaves dRdata unchanged.
REQ-026 Next grant is evaluated in the IDLE cycle after a ready pulse; minimum transaction is 3 cycles from request to ready with mAck on its first cycle.
REQ-027 mAck in IDLE is ignored.
REQ-028 stallF = ifReq & ~ifReady; stallM = (memRd|memWr) & ~dReady; both combinational.
REQ-029 A request dropped mid-transaction does not abort it: the memory cycle completes and the ready pulse is still issued.
REQ-030 A 4-bit counter clears on grant and increments each BUSY cycle without mAck.
REQ-031 Counter reaching TMO: busErr set, mRd/mWr drop, captured data forced to 0, ready pulses, state returns to IDLE.
REQ-032 busErr stays set until reset.

Reset
REQ-033 rst=0 at a clock edge forces IDLE, counter 0, and every output register (ifRdata, dRdata, mAddr, mWdata, mRd, mWr, ready pulses, busErr) to 0.
REQ-034 Reset mid-transaction abandons it with no ready pulse; a later mAck is ignored.

Structure
REQ-035 State encodings and the default TMO value live in the shared pipeline package.
REQ-036 The timeout counter is one sub-module, arb_timeout_ctr: clear, enable, terminal-count output.

Verification
REQ-037 ifReq=1, ifAddr=0x40, mAck one cycle after mRd with mRdata=0x8C010004 -> ifRdata=0x8C010004, ifReady single pulse, stallF high until that pulse.
REQ-038 ifReq and memRd both raised, dAddr=0x100 -> mAddr=0x100 served first; fetch granted only after dReady, in the following IDLE cycle.
REQ-039 memWr, dAddr=0x20, dWdata=0xDEADBEEF -> mWr with mWdata=0xDEADBEEF held until mAck; dRdata unchanged; dReady pulses.
REQ-040 mAck never asserted, TMO=15 -> busErr=1 after 15 BUSY cycles, ready pulses with data 0, busErr still 1 after 100 idle cycles.
REQ-041 rst=0 during D_BUSY, then mAck -> IDLE, all outputs 0, no dReady pulse, no state change on mAck.
